// File: rtl/genesis_pad_pkg.sv
// Shared constants for the Genesis pad emulator and the host-side reader.
// Pin/button indices, select-phase encoding and the pin mux function.
package genesis_pad_pkg;

  localparam int PIN_CS = 5;
  localparam int PIN_BA = 4;
  localparam int PIN_UZ = 3;
  localparam int PIN_DY = 2;
  localparam int PIN_LX = 1;
  localparam int PIN_RM = 0;

  localparam int BTN_Z = 11;
  localparam int BTN_Y = 10;
  localparam int BTN_X = 9;
  localparam int BTN_M = 8;
  localparam int BTN_S = 7;
  localparam int BTN_C = 6;
  localparam int BTN_B = 5;
  localparam int BTN_A = 4;
  localparam int BTN_U = 3;
  localparam int BTN_D = 2;
  localparam int BTN_L = 1;
  localparam int BTN_R = 0;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_ONE  = 3'd1,
    PH_TWO  = 3'd2,
    PH_ZERO = 3'd3,
    PH_ONES = 3'd4
  } phase_e;

  // Wraps 4 -> 1; only a timeout returns to idle.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_ONE;
    unique case (p)
      PH_IDLE: n = PH_ONE;
      PH_ONE:  n = PH_TWO;
      PH_TWO:  n = PH_ZERO;
      PH_ZERO: n = PH_ONES;
      PH_ONES: n = PH_ONE;
      default: n = PH_ONE;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] pad_map(
    input logic        sel,
    input logic        six,
    input phase_e      ph,
    input logic [11:0] b
  );
    logic [5:0] p;
    logic       xyzm;
    logic       zero;
    logic       ones;
    p    = '1;
    xyzm = six && (ph == PH_ZERO);
    zero = six && (ph == PH_ZERO);
    ones = six && (ph == PH_ONES);
    if (sel) begin
      p[PIN_CS] = ~b[BTN_C];
      p[PIN_BA] = ~b[BTN_B];
      if (xyzm) begin
        p[PIN_UZ] = ~b[BTN_Z];
        p[PIN_DY] = ~b[BTN_Y];
        p[PIN_LX] = ~b[BTN_X];
        p[PIN_RM] = ~b[BTN_M];
      end else begin
        p[PIN_UZ] = ~b[BTN_U];
        p[PIN_DY] = ~b[BTN_D];
        p[PIN_LX] = ~b[BTN_L];
        p[PIN_RM] = ~b[BTN_R];
      end
    end else begin
      p[PIN_CS] = ~b[BTN_S];
      p[PIN_BA] = ~b[BTN_A];
      unique case (1'b1)
        zero: begin
          p[PIN_UZ] = 1'b0;
          p[PIN_DY] = 1'b0;
          p[PIN_LX] = 1'b0;
          p[PIN_RM] = 1'b0;
        end
        ones: begin
          p[PIN_UZ] = 1'b1;
          p[PIN_DY] = 1'b1;
          p[PIN_LX] = 1'b1;
          p[PIN_RM] = 1'b1;
        end
        default: begin
          p[PIN_UZ] = ~b[BTN_U];
          p[PIN_DY] = ~b[BTN_D];
          p[PIN_LX] = 1'b0;
          p[PIN_RM] = 1'b0;
        end
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/genesis_select_sync.sv
// Two-flop synchronizer for the console SELECT line,
// plus single-cycle rise/fall strobes on the synced level.
module genesis_select_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // All flops reset low so a pin held high at release yields only a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/genesis_pad_emulator.sv
// Genesis 3/6-button pad emulator: select-phase counter,
// idle timeout and registered active-low pin mux.
module genesis_pad_emulator
  import genesis_pad_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 75000
) (
  input  logic        iCLK,
  input  logic        iN_RESET,
  input  logic        iSELECT,
  input  logic [11:0] iBUTTONS,
  input  logic        iSIX_BUTTON,
  output logic [5:0]  oGENPAD,
  output logic [2:0]  oPHASE
);

  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_TICKS);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_TICKS - 1);

  logic          sel_s;
  logic          sel_rise;
  logic          sel_fall;
  logic          sel_edge;
  logic          timeout;
  logic [IW-1:0] idle;
  phase_e        ph;
  phase_e        ph_next;

  genesis_select_sync u_sync (
    .clk   (iCLK),
    .rst_n (iN_RESET),
    .pin   (iSELECT),
    .level (sel_s),
    .rise  (sel_rise),
    .fall  (sel_fall)
  );

  // A same-cycle edge suppresses the timeout.
  always_comb begin
    sel_edge = sel_rise | sel_fall;
    timeout  = !sel_edge && (idle == IDLE_LAST);
    ph_next  = ph;
    unique case (1'b1)
      sel_fall: ph_next = next_phase(ph);
      timeout:  ph_next = PH_IDLE;
      default:  ph_next = ph;
    endcase
  end

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      idle    <= '0;
      ph      <= PH_IDLE;
      oGENPAD <= '1;
    end else begin
      if (sel_edge) begin
        idle <= '0;
      end else if (idle != IDLE_MAX) begin
        idle <= idle + 1'b1;
      end
      ph      <= ph_next;
      oGENPAD <= pad_map(sel_s, iSIX_BUTTON, ph_next, iBUTTONS);
    end
  end

  assign oPHASE = ph;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// Scoreboard bench for genesis_pad_emulator: stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares.
module tb_genesis_pad_emulator;

  localparam int T = 1500;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [11:0] buttons;
  logic        six;
  logic [5:0]  pad;
  logic [2:0]  phase;

  typedef struct {
    int         due;
    logic [5:0] pad;
    logic [2:0] ph;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  genesis_pad_emulator #(.TIMEOUT_TICKS(T)) dut (
    .iCLK        (clk),
    .iN_RESET    (rst_n),
    .iSELECT     (sel),
    .iBUTTONS    (buttons),
    .iSIX_BUTTON (six),
    .oGENPAD     (pad),
    .oPHASE      (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.due != cyc) begin
        failures++;
        $display("FAIL %s missed: due=%0d now=%0d",
                 mon_e.name, mon_e.due, cyc);
      end else if (pad !== mon_e.pad || phase !== mon_e.ph) begin
        failures++;
        $display("FAIL %s @%0d: pad=%b phase=%0d, want pad=%b phase=%0d",
                 mon_e.name, cyc, pad, phase, mon_e.pad, mon_e.ph);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input logic [5:0] p,
                           input logic [2:0] ph, input string nm);
    exp_t e;
    e.due  = cyc + d;
    e.pad  = p;
    e.ph   = ph;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic sel_to(input logic v, input logic [5:0] p,
                        input logic [2:0] ph, input string nm);
    sel = v;
    expect_at(3, p, ph, nm);
  endtask

  // Patterns with only Z and M pressed, indexed by phase.
  logic [5:0] low_zm  [5];
  logic [5:0] high_zm [5];

  initial begin
    low_zm  = '{6'b111100, 6'b111100, 6'b111100, 6'b110000, 6'b111111};
    high_zm = '{6'b111111, 6'b111111, 6'b111111, 6'b110110, 6'b111111};
    rst_n   = 1'b0;
    sel     = 1'b1;
    buttons = 12'h000;
    six     = 1'b0;

    tick(1);
    expect_at(0, 6'b111111, 3'd0, "reset");
    tick(2);
    rst_n = 1'b1;
    expect_at(2, 6'b111100, 3'd0, "post_rst_low");
    expect_at(3, 6'b111111, 3'd0, "post_rst_high");
    tick(20);
    expect_at(0, 6'b111111, 3'd0, "hold_high");

    // 3-button: A+S+U pressed
    buttons = 12'h098;
    expect_at(1, 6'b110111, 3'd0, "btn_3b");
    tick(20);
    for (int i = 0; i < 4; i++) begin
      expect_at(2, 6'b110111, 3'(i), "3b_pre_low");
      sel_to(1'b0, 6'b000100, 3'(i + 1), "3b_low");
      tick(1000);
      expect_at(2, 6'b000100, 3'(i + 1), "3b_pre_high");
      sel_to(1'b1, 6'b110111, 3'(i + 1), "3b_high");
      if (i == 2) begin
        tick(20);
        six = 1'b1;
        expect_at(1, 6'b111111, 3'd3, "six_on");
        tick(20);
        six = 1'b0;
        expect_at(1, 6'b110111, 3'd3, "six_off");
        tick(960);
      end else begin
        tick(1000);
      end
    end
    tick(T + 10);
    expect_at(0, 6'b110111, 3'd0, "3b_idle");

    // 6-button: Z+M pressed, continuous toggling
    six     = 1'b1;
    buttons = 12'h900;
    expect_at(1, 6'b111111, 3'd0, "6b_idle");
    tick(20);
    for (int i = 0; i < 5; i++) begin
      sel_to(1'b0, low_zm[(i % 4) + 1], 3'((i % 4) + 1), "6b_low");
      tick(20);
      sel_to(1'b1, high_zm[(i % 4) + 1], 3'((i % 4) + 1), "6b_high");
      tick(20);
    end
    sel_to(1'b0, low_zm[2], 3'd2, "6b_low2");
    tick(T + 2);
    expect_at(0, 6'b111100, 3'd2, "pre_timeout");
    expect_at(1, 6'b111100, 3'd0, "timeout");
    tick(10);
    sel_to(1'b1, 6'b111111, 3'd0, "rise_no_count");
    tick(20);
    sel_to(1'b0, 6'b111100, 3'd1, "fall_after_to");
    tick(20);
    sel_to(1'b1, 6'b111111, 3'd1, "rise_ph1");
    tick(T);
    expect_at(2, 6'b111111, 3'd1, "edge_vs_to_pre");
    sel_to(1'b0, 6'b111100, 3'd2, "edge_vs_to");
    tick(20);
    sel_to(1'b1, 6'b111111, 3'd2, "rise_ph2");
    tick(20);
    sel_to(1'b0, 6'b110000, 3'd3, "low3");
    tick(T + 2);
    expect_at(0, 6'b110000, 3'd3, "pre_to3");
    expect_at(1, 6'b111100, 3'd0, "to_low3");
    tick(10);

    // Walk to ph=3 with SELECT high, then reset
    sel_to(1'b1, 6'b111111, 3'd0, "rst_walk_rise0");
    tick(20);
    for (int p = 1; p < 4; p++) begin
      sel_to(1'b0, low_zm[p], 3'(p), "rst_walk_low");
      tick(20);
      sel_to(1'b1, high_zm[p], 3'(p), "rst_walk_high");
      tick(20);
    end
    tick(5);
    rst_n = 1'b0;
    expect_at(0, 6'b111111, 3'd0, "async_rst");
    tick(3);
    rst_n = 1'b1;
    expect_at(1, 6'b111100, 3'd0, "rel_low");
    expect_at(3, 6'b111111, 3'd0, "rel_high");
    tick(20);
    sel_to(1'b0, 6'b111100, 3'd1, "first_fall");
    tick(20);

    for (int w = 0; w < 20 && q.size() > 0; w++) tick(1);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
